ex_operand_stage: RTL and testbench

- ID/EX pipeline register plus operand-select logic, directly upstream of the ALU.
- Latches decoded fields and controls from the decode stage.
- Forwards results from the EX/MEM and MEM/WB stages and selects the immediate.
- Drives the ALU A, B and ALUOp inputs, and detects load-use hazards to stall fetch/decode.

---
 rtl/ex_operand_stage.sv | 148 ++++++++++++++
 tb/tb_ex_operand_stage.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_operand_stage.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : ex_operand_stage
// Brief    : ID/EX pipeline register with forwarding, immediate select and
//            load-use hazard detection feeding the ALU.
// Revision : 1.0 - initial release
// ============================================================================
module ex_operand_stage #(
  parameter int XLEN = 32,
  parameter int RW   = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_rs_data,
  input  logic [XLEN-1:0] id_rt_data,
  input  logic [RW-1:0]   id_rs,
  input  logic [RW-1:0]   id_rt,
  input  logic [RW-1:0]   id_rd,
  input  logic [15:0]     id_imm,
  input  logic            id_zero_ext,
  input  logic            id_uses_rt,
  input  logic            id_alusrc,
  input  logic [2:0]      id_aluop,
  input  logic            id_regdst,
  input  logic            id_regwrite,
  input  logic            id_memread,
  input  logic            id_memwrite,
  input  logic            id_memtoreg,
  input  logic            hold,
  input  logic            flush,
  input  logic            exm_regwrite,
  input  logic [RW-1:0]   exm_wreg,
  input  logic [XLEN-1:0] exm_result,
  input  logic            mwb_regwrite,
  input  logic [RW-1:0]   mwb_wreg,
  input  logic [XLEN-1:0] mwb_data,
  output logic            stall,
  output logic            ex_valid,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [2:0]      alu_op,
  output logic [XLEN-1:0] store_data,
  output logic [RW-1:0]   ex_wreg,
  output logic            ex_regwrite,
  output logic            ex_memread,
  output logic            ex_memwrite,
  output logic            ex_memtoreg
);

  logic            r_valid;
  logic [XLEN-1:0] r_rs_data;
  logic [XLEN-1:0] r_rt_data;
  logic [RW-1:0]   r_rs;
  logic [RW-1:0]   r_rt;
  logic [RW-1:0]   r_wreg;
  logic [XLEN-1:0] r_ext_imm;
  logic            r_alusrc;
  logic [2:0]      r_aluop;
  logic            r_regwrite;
  logic            r_memread;
  logic            r_memwrite;
  logic            r_memtoreg;

  logic [XLEN-1:0] w_ext_imm;
  logic [XLEN-1:0] w_fwd_rs;
  logic [XLEN-1:0] w_fwd_rt;

  assign w_ext_imm = {{(XLEN-16){~id_zero_ext & id_imm[15]}}, id_imm};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid    <= 1'b0;
      r_rs_data  <= '0;
      r_rt_data  <= '0;
      r_rs       <= '0;
      r_rt       <= '0;
      r_wreg     <= '0;
      r_ext_imm  <= '0;
      r_alusrc   <= 1'b0;
      r_aluop    <= 3'b000;
      r_regwrite <= 1'b0;
      r_memread  <= 1'b0;
      r_memwrite <= 1'b0;
      r_memtoreg <= 1'b0;
    end else if (!hold) begin
      if (flush || stall) begin
        // Bubble: operand fields are don't-care once valid and controls drop.
        r_valid    <= 1'b0;
        r_aluop    <= 3'b000;
        r_regwrite <= 1'b0;
        r_memread  <= 1'b0;
        r_memwrite <= 1'b0;
        r_memtoreg <= 1'b0;
      end else begin
        r_valid    <= id_valid;
        r_rs_data  <= id_rs_data;
        r_rt_data  <= id_rt_data;
        r_rs       <= id_rs;
        r_rt       <= id_rt;
        r_wreg     <= id_regdst ? id_rd : id_rt;
        r_ext_imm  <= w_ext_imm;
        r_alusrc   <= id_alusrc;
        r_aluop    <= id_aluop;
        r_regwrite <= id_regwrite & id_valid;
        r_memread  <= id_memread  & id_valid;
        r_memwrite <= id_memwrite & id_valid;
        r_memtoreg <= id_memtoreg & id_valid;
      end
    end
  end

  // EX/MEM is the younger producer, so it takes precedence; $0 is never forwarded.
  always_comb begin
    w_fwd_rs = r_rs_data;
    if (r_rs != '0 && exm_regwrite && exm_wreg == r_rs)
      w_fwd_rs = exm_result;
    else if (r_rs != '0 && mwb_regwrite && mwb_wreg == r_rs)
      w_fwd_rs = mwb_data;
  end

  always_comb begin
    w_fwd_rt = r_rt_data;
    if (r_rt != '0 && exm_regwrite && exm_wreg == r_rt)
      w_fwd_rt = exm_result;
    else if (r_rt != '0 && mwb_regwrite && mwb_wreg == r_rt)
      w_fwd_rt = mwb_data;
  end

  assign alu_a      = w_fwd_rs;
  assign alu_b      = r_alusrc ? r_ext_imm : w_fwd_rt;
  assign store_data = w_fwd_rt;
  assign alu_op     = r_aluop;

  assign ex_valid    = r_valid;
  assign ex_wreg     = r_valid ? r_wreg : '0;
  assign ex_regwrite = r_valid & r_regwrite;
  assign ex_memread  = r_valid & r_memread;
  assign ex_memwrite = r_valid & r_memwrite;
  assign ex_memtoreg = r_valid & r_memtoreg;

  // A load in EX cannot supply its value until MEM, so a dependent decode must wait.
  assign stall = id_valid & r_valid & ex_memread & (r_rt != '0)
               & ((r_rt == id_rs) | (id_uses_rt & (r_rt == id_rt))) & ~hold;

endmodule
`default_nettype wire

// File: tb/tb_ex_operand_stage.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_ex_operand_stage
// Brief    : Directed and randomized self-checking bench for ex_operand_stage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ex_operand_stage;
  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [31:0] id_rs_data, id_rt_data;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [15:0] id_imm;
  logic        id_zero_ext, id_uses_rt, id_alusrc;
  logic [2:0]  id_aluop;
  logic        id_regdst, id_regwrite, id_memread, id_memwrite, id_memtoreg;
  logic        hold, flush;
  logic        exm_regwrite;
  logic [4:0]  exm_wreg;
  logic [31:0] exm_result;
  logic        mwb_regwrite;
  logic [4:0]  mwb_wreg;
  logic [31:0] mwb_data;
  logic        stall, ex_valid;
  logic [31:0] alu_a, alu_b, store_data;
  logic [2:0]  alu_op;
  logic [4:0]  ex_wreg;
  logic        ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ex_operand_stage #(.XLEN(32), .RW(5)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_imm(id_imm),
    .id_zero_ext(id_zero_ext), .id_uses_rt(id_uses_rt), .id_alusrc(id_alusrc),
    .id_aluop(id_aluop), .id_regdst(id_regdst), .id_regwrite(id_regwrite),
    .id_memread(id_memread), .id_memwrite(id_memwrite), .id_memtoreg(id_memtoreg),
    .hold(hold), .flush(flush),
    .exm_regwrite(exm_regwrite), .exm_wreg(exm_wreg), .exm_result(exm_result),
    .mwb_regwrite(mwb_regwrite), .mwb_wreg(mwb_wreg), .mwb_data(mwb_data),
    .stall(stall), .ex_valid(ex_valid), .alu_a(alu_a), .alu_b(alu_b),
    .alu_op(alu_op), .store_data(store_data), .ex_wreg(ex_wreg),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .ex_memwrite(ex_memwrite), .ex_memtoreg(ex_memtoreg)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the instruction sitting in EX, as a plain record.
  logic        m_init = 1'b0;
  logic        m_datak;
  logic        m_valid, m_alusrc, m_rw, m_mr, m_mw, m_mt;
  logic [31:0] m_rsd, m_rtd, m_imm;
  logic [4:0]  m_rs, m_rt, m_wreg;
  logic [2:0]  m_op;

  function automatic logic model_stall();
    return id_valid && m_valid && m_mr && (m_rt != 5'd0) && !hold &&
           ((m_rt == id_rs) || (id_uses_rt && m_rt == id_rt));
  endfunction

  function automatic logic [31:0] model_fwd(input logic [4:0] s, input logic [31:0] latched);
    if (s != 5'd0 && exm_regwrite && exm_wreg == s) return exm_result;
    if (s != 5'd0 && mwb_regwrite && mwb_wreg == s) return mwb_data;
    return latched;
  endfunction

  always @(posedge clk) begin : model
    logic st;
    st = m_init && model_stall();
    if (reset) begin
      m_init = 1'b1; m_datak = 1'b1; m_valid = 1'b0; m_alusrc = 1'b0;
      m_rw = 1'b0; m_mr = 1'b0; m_mw = 1'b0; m_mt = 1'b0;
      m_rsd = 32'd0; m_rtd = 32'd0; m_imm = 32'd0;
      m_rs = 5'd0; m_rt = 5'd0; m_wreg = 5'd0; m_op = 3'd0;
    end else if (m_init && !hold) begin
      if (flush || st) begin
        m_datak = 1'b0; m_valid = 1'b0; m_op = 3'd0;
        m_rw = 1'b0; m_mr = 1'b0; m_mw = 1'b0; m_mt = 1'b0;
      end else begin
        m_datak = 1'b1;
        m_valid = id_valid;
        m_rsd = id_rs_data; m_rtd = id_rt_data;
        m_rs = id_rs; m_rt = id_rt;
        m_wreg = id_regdst ? id_rd : id_rt;
        m_imm = id_zero_ext ? {16'd0, id_imm} : 32'($signed(id_imm));
        m_alusrc = id_alusrc; m_op = id_aluop;
        m_rw = id_regwrite && id_valid; m_mr = id_memread && id_valid;
        m_mw = id_memwrite && id_valid; m_mt = id_memtoreg && id_valid;
      end
    end
  end

  always @(negedge clk) begin : compare
    if (m_init) begin
      chk("cmp_stall",    32'(stall),       32'(model_stall()));
      chk("cmp_ex_valid", 32'(ex_valid),    32'(m_valid));
      chk("cmp_alu_op",   32'(alu_op),      32'(m_op));
      chk("cmp_regwrite", 32'(ex_regwrite), 32'(m_rw));
      chk("cmp_memread",  32'(ex_memread),  32'(m_mr));
      chk("cmp_memwrite", 32'(ex_memwrite), 32'(m_mw));
      chk("cmp_memtoreg", 32'(ex_memtoreg), 32'(m_mt));
      if (m_datak) begin
        chk("cmp_alu_a",      alu_a,      model_fwd(m_rs, m_rsd));
        chk("cmp_alu_b",      alu_b,      m_alusrc ? m_imm : model_fwd(m_rt, m_rtd));
        chk("cmp_store_data", store_data, model_fwd(m_rt, m_rtd));
        chk("cmp_ex_wreg",    32'(ex_wreg), m_valid ? 32'(m_wreg) : 32'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reset = 1'b0; hold = 1'b0; flush = 1'b0;
    id_valid = 1'b0; id_rs_data = 32'd0; id_rt_data = 32'd0;
    id_rs = 5'd0; id_rt = 5'd0; id_rd = 5'd0; id_imm = 16'd0;
    id_zero_ext = 1'b0; id_uses_rt = 1'b0; id_alusrc = 1'b0; id_aluop = 3'd0;
    id_regdst = 1'b0; id_regwrite = 1'b0; id_memread = 1'b0;
    id_memwrite = 1'b0; id_memtoreg = 1'b0;
    exm_regwrite = 1'b0; exm_wreg = 5'd0; exm_result = 32'd0;
    mwb_regwrite = 1'b0; mwb_wreg = 5'd0; mwb_data = 32'd0;
  endtask

  task automatic load_lw4();
    idle();
    id_valid = 1'b1; id_rs = 5'd1; id_rt = 5'd4; id_imm = 16'h0008;
    id_alusrc = 1'b1; id_aluop = 3'b010;
    id_regwrite = 1'b1; id_memread = 1'b1; id_memtoreg = 1'b1;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_ex_valid", 32'(ex_valid), 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_b", alu_b, 32'd0);
    chk("rst_store_data", store_data, 32'd0);
    chk("rst_alu_op", 32'(alu_op), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);

    // add r3, r1, r2
    id_valid = 1'b1; id_rs = 5'd1; id_rt = 5'd2; id_rd = 5'd3;
    id_rs_data = 32'h5; id_rt_data = 32'h7; id_aluop = 3'b010;
    id_regdst = 1'b1; id_regwrite = 1'b1;
    tick();
    chk("add_alu_a", alu_a, 32'h5);
    chk("add_alu_b", alu_b, 32'h7);
    chk("add_alu_op", 32'(alu_op), 32'h2);
    chk("add_regwrite", 32'(ex_regwrite), 32'd1);
    chk("add_wreg", 32'(ex_wreg), 32'd3);

    // addi / ori with the same raw immediate
    idle();
    id_valid = 1'b1; id_rt = 5'd5; id_imm = 16'hFFF0; id_alusrc = 1'b1; id_regwrite = 1'b1;
    tick();
    chk("addi_alu_b", alu_b, 32'hFFFF_FFF0);
    chk("addi_wreg", 32'(ex_wreg), 32'd5);
    id_zero_ext = 1'b1;
    tick();
    chk("ori_alu_b", alu_b, 32'h0000_FFF0);

    // forwarding priority
    idle();
    id_valid = 1'b1; id_rs = 5'd3; id_rs_data = 32'h11; id_aluop = 3'b010;
    tick();
    idle();
    exm_regwrite = 1'b1; exm_wreg = 5'd3; exm_result = 32'hAA;
    mwb_regwrite = 1'b1; mwb_wreg = 5'd3; mwb_data = 32'hBB;
    #1 chk("fwd_exm_wins", alu_a, 32'hAA);
    exm_wreg = 5'd0;
    #1 chk("fwd_mwb", alu_a, 32'hBB);
    idle();
    id_valid = 1'b1; id_rs = 5'd0; id_rs_data = 32'h33;
    tick();
    exm_regwrite = 1'b1; exm_wreg = 5'd0; exm_result = 32'hAA;
    mwb_regwrite = 1'b1; mwb_wreg = 5'd0; mwb_data = 32'hBB;
    #1 chk("fwd_r0_never", alu_a, 32'h33);

    // load-use hazard
    load_lw4();
    tick();
    idle();
    id_valid = 1'b1; id_rs = 5'd6; id_rt = 5'd4; id_rd = 5'd8; id_uses_rt = 1'b1;
    id_aluop = 3'b110; id_regdst = 1'b1; id_regwrite = 1'b1;
    #1 chk("lu_stall", 32'(stall), 32'd1);
    tick();
    chk("lu_bubble_valid", 32'(ex_valid), 32'd0);
    chk("lu_bubble_rw", 32'(ex_regwrite), 32'd0);
    chk("lu_bubble_mr", 32'(ex_memread), 32'd0);
    chk("lu_bubble_op", 32'(alu_op), 32'd0);
    chk("lu_bubble_stall", 32'(stall), 32'd0);
    load_lw4();
    tick();
    idle();
    id_valid = 1'b1; id_rs = 5'd5; id_rt = 5'd4; id_uses_rt = 1'b0;
    #1 chk("lu_no_rt_use", 32'(stall), 32'd0);

    // flush, then hold with flush
    idle();
    id_valid = 1'b1; id_rs = 5'd2; id_regwrite = 1'b1; id_aluop = 3'b001; flush = 1'b1;
    tick();
    chk("flush_valid", 32'(ex_valid), 32'd0);
    chk("flush_rw", 32'(ex_regwrite), 32'd0);
    load_lw4();
    tick();
    idle();
    hold = 1'b1; flush = 1'b1;
    id_valid = 1'b1; id_rs = 5'd4; id_rt = 5'd4; id_uses_rt = 1'b1; id_regwrite = 1'b1;
    #1 chk("hold_stall", 32'(stall), 32'd0);
    tick();
    chk("hold_valid", 32'(ex_valid), 32'd1);
    chk("hold_mr", 32'(ex_memread), 32'd1);
    chk("hold_wreg", 32'(ex_wreg), 32'd4);

    // sw with rt from MEM/WB, then reset while held
    idle();
    id_valid = 1'b1; id_rs = 5'd2; id_rs_data = 32'h100; id_rt = 5'd7;
    id_imm = 16'h0010; id_alusrc = 1'b1; id_memwrite = 1'b1; id_aluop = 3'b010;
    tick();
    idle();
    mwb_regwrite = 1'b1; mwb_wreg = 5'd7; mwb_data = 32'h1234;
    #1 chk("sw_store_data", store_data, 32'h1234);
    chk("sw_alu_b", alu_b, 32'h10);
    chk("sw_memwrite", 32'(ex_memwrite), 32'd1);
    hold = 1'b1; reset = 1'b1;
    tick();
    chk("rsthold_valid", 32'(ex_valid), 32'd0);
    chk("rsthold_alu_a", alu_a, 32'd0);
    chk("rsthold_alu_b", alu_b, 32'd0);
    chk("rsthold_store", store_data, 32'd0);
    chk("rsthold_mw", 32'(ex_memwrite), 32'd0);
    idle();

    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      reset        = ($urandom_range(0, 59) == 0);
      hold         = ($urandom_range(0, 4) == 0);
      flush        = ($urandom_range(0, 6) == 0);
      id_valid     = ($urandom_range(0, 5) != 0);
      id_rs_data   = $urandom; id_rt_data = $urandom;
      id_rs        = 5'($urandom_range(0, 7));
      id_rt        = 5'($urandom_range(0, 7));
      id_rd        = 5'($urandom_range(0, 7));
      id_imm       = 16'($urandom);
      id_zero_ext  = 1'($urandom);
      id_uses_rt   = 1'($urandom);
      id_alusrc    = 1'($urandom);
      id_aluop     = 3'($urandom);
      id_regdst    = 1'($urandom);
      id_regwrite  = 1'($urandom);
      id_memread   = ($urandom_range(0, 2) == 0);
      id_memwrite  = 1'($urandom);
      id_memtoreg  = 1'($urandom);
      exm_regwrite = 1'($urandom);
      exm_wreg     = 5'($urandom_range(0, 7));
      exm_result   = $urandom;
      mwb_regwrite = 1'($urandom);
      mwb_wreg     = ($urandom_range(0, 2) == 0) ? exm_wreg : 5'($urandom_range(0, 7));
      mwb_data     = $urandom;
      tick();
    end

    idle();
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
